multi_timer: RTL and testbench
==============================

# multi_timer

Parametrised multi-channel programmable timer on the CPU's memory-mapped device bus, next to the bridge. Each channel counts down from a preset and can run one-shot, auto-reload or silent free-run. Each channel has a sticky interrupt-pending bit and its own interrupt mask. The OR of all unmasked pending bits drives the CPU's external interrupt line, and software can identify the source through a per-channel vector.

## Interface
- NUM_CH, 2: number of channels, 1..8
- CNT_W, 32: counter and preset width, 8..32; register reads are zero-extended to 32 bits
- BASE_ADDR, 32'h0000_7F00: word-aligned base address; each channel occupies a 16-byte window at BASE_ADDR + 16*ch
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- addr  in  32  byte address from the bridge
- we  in  1  write strobe, sampled on the rising clk edge
- wdata  in  32  write data
- rdata  out  32  combinational read data for addr
- irq  out  1  OR over channels of (pending & IM)
- irq_vec  out  NUM_CH  per-channel (pending & IM)

## Operation
- Per-channel register map, by offset:
  - +0 CTRL: bit0 EN, bits2:1 MODE, bit3 IM; bits 31:4 read 0.
  - +4 PRESET: read/write, CNT_W bits.
  - +8 COUNT: read-only; writes are ignored.
  - +C STATUS: bit0 PENDING; writing 1 clears it, writing 0 has no effect.
- MODE values:
  - 00 one-shot: on expiry, set PENDING, clear EN, go to IDLE.
  - 01 auto-reload: on expiry, set PENDING, reload COUNT from PRESET, stay counting.
  - 10 free-run: on expiry, reload COUNT from PRESET without setting PENDING.
  - 11 is treated as 00.
- Channel FSM (states IDLE, LOAD, COUNTING, FIRE):
  - IDLE: if EN=1, go to LOAD.
  - LOAD: COUNT <= PRESET; go to COUNTING.
  - COUNTING: if EN=0, go to IDLE with COUNT frozen. Else if COUNT <= 1, set COUNT <= 0 and go to FIRE. Else COUNT <= COUNT-1.
  - FIRE: apply the MODE action. Reload modes go to COUNTING with COUNT = PRESET.
- PRESET=0 behaves as PRESET=1.
- Addresses outside [BASE_ADDR, BASE_ADDR + 16*NUM_CH): rdata = 0 and writes are ignored. addr[1:0] is ignored.

## Timing
- Reset clears EN, MODE, IM, PRESET, COUNT and PENDING, and puts every FSM in IDLE. After reset, irq=0, irq_vec=0 and rdata=0 for CTRL, PRESET and COUNT.
- Reset takes effect on the same edge even mid-count or in FIRE; any pending write that edge is discarded.
- Bus writes take effect on the capturing edge. Reads are same-cycle combinational.
- Expiry latency: EN is written at edge E0 with preset P≥1.
  - E1: LOAD.
  - E2: COUNTING with COUNT=P.
  - E(P+1): COUNT reaches 1.
  - E(P+2): FIRE.
  - E(P+3): PENDING=1; irq rises after E(P+3) if IM=1.
- Auto-reload period is P+2 cycles.
- A CTRL write in the same cycle as FIRE: the written CTRL fields win, but PENDING is still set if the old MODE required it.
- A W1C clear in the same cycle as a PENDING set: the set wins.
- A PRESET write while counting affects only the next LOAD or reload.
- Clearing IM masks irq without clearing PENDING. Setting IM with PENDING=1 raises irq on the next cycle.
- Channels are fully independent; simultaneous expiries on several channels all set PENDING.

## Structure
- Package timer_pkg holds:
  - the state enum
  - MODE_ONESHOT, MODE_RELOAD, MODE_FREERUN
  - register offsets CTRL_OFF, PRESET_OFF, COUNT_OFF, STATUS_OFF
  - CH_STRIDE = 16
- Sub-module timer_channel (CTRL, PRESET, COUNT, STATUS and FSM for one channel) is instantiated NUM_CH times in a generate loop.
- The top level handles address decode, the read mux and the irq OR-reduction.

## Test plan
- Reset sweep: write every register, assert reset mid-count → all reads 0, irq=0, irq_vec=0, all FSMs IDLE.
- One-shot, ch0: PRESET=5, CTRL=0x9 → irq rises exactly 8 edges after the write; CTRL reads 0x8 (EN=0); a W1C write to STATUS drops irq the next cycle.
- Auto-reload, ch1: PRESET=3, CTRL=0xB → PENDING is re-set every 5 cycles; clearing it between expiries yields periodic irq pulses; a PRESET write to 6 mid-count changes the period to 8 only after the next reload.
- Free-run plus mask: MODE=10 with IM=1 → irq stays 0 and COUNT wraps from PRESET. Then one-shot expiry with IM=0 → PENDING=1, irq=0; setting IM → irq=1.
- Collision cases: W1C on the same cycle as FIRE → PENDING stays 1. EN=0 written mid-count → COUNT freezes and reads stable. Re-enable → COUNT restarts from PRESET.
- Decode: NUM_CH=3, CNT_W=16; write 0x12345 to PRESET → reads 0x2345. Access BASE+0x30 → rdata=0 and no channel changes. Simultaneous expiry of ch0 and ch2 → irq_vec=3'b101.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the multi-channel programmable timer.
package timer_pkg;

    // Per-channel sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD     = 2'd1,
        ST_COUNTING = 2'd2,
        ST_FIRE     = 2'd3
    } state_t;

    // MODE field encodings; the fourth code behaves as one-shot.
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;
    localparam logic [1:0] MODE_FREERUN = 2'b10;

    // Byte offsets of the registers inside a channel window.
    localparam logic [3:0] CTRL_OFF   = 4'h0;
    localparam logic [3:0] PRESET_OFF = 4'h4;
    localparam logic [3:0] COUNT_OFF  = 4'h8;
    localparam logic [3:0] STATUS_OFF = 4'hC;

    // Size in bytes of one channel window.
    localparam int CH_STRIDE = 16;

    // CTRL register layout, packed so it maps directly onto wdata[3:0].
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

    // Free-run is the only mode that expires silently.
    function automatic logic mode_sets_pending(input logic [1:0] mode);
        return mode != MODE_FREERUN;
    endfunction

    // Auto-reload and free-run restart the count after expiry.
    function automatic logic mode_reloads(input logic [1:0] mode);
        return (mode == MODE_RELOAD) || (mode == MODE_FREERUN);
    endfunction

endpackage

// File: rtl/multi_timer_if.sv
// Memory-mapped device bus between the bridge and the timer block.
interface multi_timer_if;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;

    // Bridge side drives address/write, timer returns read data.
    modport master (output addr, output we, output wdata, input rdata);
    modport slave  (input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/timer_channel.sv
// One timer channel: CTRL/PRESET/COUNT/STATUS registers and its sequencer.
module timer_channel
    import timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic [3:0]  reg_off,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq_req
);

    ctrl_t            ctrl;
    logic [CNT_W-1:0] preset;
    logic [CNT_W-1:0] count;
    logic             pending;
    state_t           state;
    state_t           state_nxt;

    logic do_load;
    logic do_decrement;
    logic do_zero;
    logic do_set_pending;
    logic do_clear_en;

    logic wr_ctrl;
    logic wr_preset;
    logic wr_status;
    logic count_last;
    logic unused_wdata;

    assign wr_ctrl    = sel && we && (reg_off == CTRL_OFF);
    assign wr_preset  = sel && we && (reg_off == PRESET_OFF);
    assign wr_status  = sel && we && (reg_off == STATUS_OFF);
    // A preset of zero expires exactly like a preset of one.
    assign count_last = count <= CNT_W'(1);
    // Upper write-data bits are meaningless when CNT_W < 32.
    assign unused_wdata = ^wdata;

    // Sequencer state register.
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decision; reload modes pass back through LOAD, giving a P+2 period.
    // NOTE: the default assignment at the top keeps every path assigned, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:     if (ctrl.en) state_nxt = ST_LOAD;
            ST_LOAD:     state_nxt = ST_COUNTING;
            ST_COUNTING: begin
                if (!ctrl.en) begin
                    state_nxt = ST_IDLE;
                end else if (count_last) begin
                    state_nxt = ST_FIRE;
                end
            end
            ST_FIRE:     state_nxt = mode_reloads(ctrl.mode) ? ST_LOAD : ST_IDLE;
        endcase
    end

    // Datapath actions requested by the current state.
    always_comb begin
        do_load        = 1'b0;
        do_decrement   = 1'b0;
        do_zero        = 1'b0;
        do_set_pending = 1'b0;
        do_clear_en    = 1'b0;
        unique case (state)
            ST_IDLE:     ;
            ST_LOAD:     do_load = 1'b1;
            ST_COUNTING: begin
                if (ctrl.en) begin
                    do_zero      = count_last;
                    do_decrement = !count_last;
                end
            end
            ST_FIRE: begin
                do_set_pending = mode_sets_pending(ctrl.mode);
                do_clear_en    = !mode_reloads(ctrl.mode);
            end
        endcase
    end

    // Registers: bus writes to CTRL override the expiry's EN clear, and a
    // pending set beats a simultaneous write-1-to-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl    <= '0;
            preset  <= '0;
            count   <= '0;
            pending <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl <= ctrl_t'(wdata[3:0]);
            end else if (do_clear_en) begin
                ctrl.en <= 1'b0;
            end

            if (wr_preset) begin
                preset <= wdata[CNT_W-1:0];
            end

            if (do_load) begin
                count <= preset;
            end else if (do_zero) begin
                count <= '0;
            end else if (do_decrement) begin
                count <= count - CNT_W'(1);
            end

            if (do_set_pending) begin
                pending <= 1'b1;
            end else if (wr_status && wdata[0]) begin
                pending <= 1'b0;
            end
        end
    end

    // Register read mux, zero-extended to the bus width.
    always_comb begin
        rdata = '0;
        unique case (reg_off)
            CTRL_OFF:   rdata = {28'd0, ctrl};
            PRESET_OFF: rdata = 32'(preset);
            COUNT_OFF:  rdata = 32'(count);
            STATUS_OFF: rdata = {31'd0, pending};
            default:    rdata = '0;
        endcase
    end

    assign irq_req = pending & ctrl.im;

endmodule

// File: rtl/multi_timer.sv
// Multi-channel timer: address decode, read mux and interrupt combining.
module multi_timer
    import timer_pkg::*;
#(
    parameter int          NUM_CH    = 2,
    parameter int          CNT_W     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic              clk,
    input  logic              reset,
    multi_timer_if.slave      bus,
    output logic              irq,
    output logic [NUM_CH-1:0] irq_vec
);

    localparam logic [31:0] SPAN = 32'(CH_STRIDE * NUM_CH);

    logic [31:0]       offset;
    logic              in_range;
    logic [2:0]        ch_idx;
    logic [3:0]        reg_off;
    logic [NUM_CH-1:0] sel;
    logic [31:0]       ch_rdata [NUM_CH];
    logic [31:0]       rdata_mux;
    logic              unused_offset;

    // Subtracting first keeps the range test correct even near the top of the map.
    assign offset        = bus.addr - BASE_ADDR;
    assign in_range      = (bus.addr >= BASE_ADDR) && (offset < SPAN);
    assign ch_idx        = offset[6:4];
    assign reg_off       = {offset[3:2], 2'b00};
    // Byte lanes within a word are ignored.
    assign unused_offset = ^offset[1:0];

    // One-hot channel select from the decoded window.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel[i] = in_range && (ch_idx == 3'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        timer_channel #(
            .CNT_W (CNT_W)
        ) u_channel (
            .clk     (clk),
            .reset   (reset),
            .sel     (sel[g]),
            .we      (bus.we),
            .reg_off (reg_off),
            .wdata   (bus.wdata),
            .rdata   (ch_rdata[g]),
            .irq_req (irq_vec[g])
        );
    end

    // Read data from the selected channel, zero outside the block.
    always_comb begin
        rdata_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel[i]) rdata_mux = ch_rdata[i];
        end
    end

    assign bus.rdata = rdata_mux;
    assign irq       = |irq_vec;

endmodule

// File: tb/tb_multi_timer.sv
// Scoreboarded bench for multi_timer: timestamp-based reference model, directed
// scenarios followed by randomized bus traffic.
module tb_multi_timer;
    import timer_pkg::*;

    localparam int          NCH  = 3;
    localparam int          CW   = 16;
    localparam logic [31:0] BASE = 32'h0000_7F00;

    logic           clk = 1'b0;
    logic           reset;
    logic           irq;
    logic [NCH-1:0] irq_vec;

    multi_timer_if bus();

    multi_timer #(
        .NUM_CH    (NCH),
        .CNT_W     (CW),
        .BASE_ADDR (BASE)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .irq     (irq),
        .irq_vec (irq_vec)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0]    addr;
        logic [31:0]    rdata;
        logic [NCH-1:0] vec;
        logic           irq;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: register contents plus timestamps of the last load.
    bit       m_en     [NCH];
    bit       m_im     [NCH];
    bit [1:0] m_mode   [NCH];
    int       m_preset [NCH];
    int       m_count  [NCH];
    bit       m_pend   [NCH];
    bit       m_active [NCH];
    int       m_load_at[NCH];
    int       m_lp     [NCH];
    int       m_start  [NCH];
    int       edge_n = 0;
    bit       model_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ra(input int ch, input logic [3:0] off);
        return BASE + 32'(16 * ch) + 32'(off);
    endfunction

    function automatic bit hit(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < 32'(16 * NCH));
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int c;
        int w;
        if (!hit(a)) return 32'd0;
        c = int'((a - BASE) >> 4);
        w = int'(((a - BASE) >> 2) & 32'd3);
        case (w)
            0:       return {28'd0, m_im[c], m_mode[c], m_en[c]};
            1:       return 32'(m_preset[c]);
            2:       return 32'(m_count[c]);
            default: return {31'd0, m_pend[c]};
        endcase
    endfunction

    function automatic logic [NCH-1:0] model_vec();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = m_pend[c] & m_im[c];
        return v;
    endfunction

    // Advance the model across one rising edge using the inputs just driven.
    // A run loaded at edge L with preset P (treated as max(P,1)) decrements
    // until edge L+P, expires at L+P+1, and reloads at L+P+2.
    task automatic model_step();
        int  wc;
        int  ww;
        bit  wr_hit;
        edge_n++;
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                m_en[c] = 0; m_im[c] = 0; m_mode[c] = 0; m_preset[c] = 0;
                m_count[c] = 0; m_pend[c] = 0; m_active[c] = 0; m_start[c] = -1;
                m_load_at[c] = 0; m_lp[c] = 0;
            end
            model_valid = 1'b1;
            return;
        end
        wr_hit = bus.we && hit(bus.addr);
        wc = int'((bus.addr - BASE) >> 4);
        ww = int'(((bus.addr - BASE) >> 2) & 32'd3);
        for (int c = 0; c < NCH; c++) begin
            bit set_p;
            int d;
            int pe;
            set_p = 0;
            if (!m_active[c]) begin
                if (m_start[c] == edge_n) begin
                    m_count[c]   = m_preset[c];
                    m_lp[c]      = m_preset[c];
                    m_load_at[c] = edge_n;
                    m_active[c]  = 1;
                    m_start[c]   = -1;
                end else if (m_en[c] && m_start[c] < 0) begin
                    m_start[c] = edge_n + 1;
                end
            end else begin
                d  = edge_n - m_load_at[c];
                pe = (m_lp[c] == 0) ? 1 : m_lp[c];
                if (d <= pe) begin
                    if (!m_en[c])     m_active[c] = 0;
                    else if (d == pe) m_count[c] = 0;
                    else              m_count[c] = m_lp[c] - d;
                end else begin
                    set_p = (m_mode[c] != 2'b10);
                    m_active[c] = 0;
                    if (m_mode[c] == 2'b01 || m_mode[c] == 2'b10) m_start[c] = edge_n + 1;
                    else                                          m_en[c] = 0;
                    if (set_p) m_pend[c] = 1;
                end
            end
            if (wr_hit && wc == c) begin
                case (ww)
                    0: begin
                        m_en[c]   = bus.wdata[0];
                        m_mode[c] = bus.wdata[2:1];
                        m_im[c]   = bus.wdata[3];
                    end
                    1: m_preset[c] = int'(bus.wdata[CW-1:0]);
                    3: if (bus.wdata[0] && !set_p) m_pend[c] = 0;
                    default: ;
                endcase
            end
        end
    endtask

    // One bus cycle: drive at the falling edge, queue the expected outputs, model the rising edge.
    task automatic cycle(input logic rst, input logic wr, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        @(negedge clk);
        reset     = rst;
        bus.we    = wr;
        bus.addr  = a;
        bus.wdata = d;
        if (model_valid) begin
            e.addr  = a;
            e.rdata = model_read(a);
            e.vec   = model_vec();
            e.irq   = |e.vec;
            exp_q.push_back(e);
        end
        @(posedge clk);
        model_step();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cycle(1'b0, 1'b1, a, d);
    endtask

    task automatic rd(input logic [31:0] a);
        cycle(1'b0, 1'b0, a, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) rd(ra(0, COUNT_OFF));
    endtask

    // Count edges until the channel's interrupt request appears; -1 on timeout.
    task automatic wait_pending(input int ch, input int limit, output int edges);
        edges = -1;
        for (int k = 1; k <= limit; k++) begin
            rd(ra(ch, COUNT_OFF));
            #1;
            if (irq_vec[ch]) begin
                edges = k;
                break;
            end
        end
    endtask

    // Monitor: compare DUT outputs with the queued expectation each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("rdata@%h", e.addr), bus.rdata, e.rdata);
                check("irq_vec", 32'(irq_vec), 32'(e.vec));
                check("irq", 32'(irq), 32'(e.irq));
            end
        end
    end

    initial begin
        int k;
        bit seen;
        reset = 1'b1; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
        cycle(1'b1, 1'b0, 32'd0, 32'd0);
        cycle(1'b1, 1'b0, 32'd0, 32'd0);

        // Post-reset state.
        for (int c = 0; c < NCH; c++)
            for (int o = 0; o < 4; o++) rd(ra(c, 4'(o * 4)));
        #1;
        check("reset_irq", 32'(irq), 32'd0);
        check("reset_vec", 32'(irq_vec), 32'd0);

        // One-shot on ch0.
        wr(ra(0, PRESET_OFF), 32'd5);
        wr(ra(0, CTRL_OFF), 32'h9);
        wait_pending(0, 40, k);
        check("oneshot_latency", 32'(k), 32'd8);
        rd(ra(0, CTRL_OFF)); #1;
        check("oneshot_ctrl", bus.rdata, 32'h8);
        wr(ra(0, STATUS_OFF), 32'd1); #1;
        check("oneshot_w1c_irq", 32'(irq), 32'd0);

        // Auto-reload on ch1 with a mid-count preset change.
        wr(ra(1, PRESET_OFF), 32'd3);
        wr(ra(1, CTRL_OFF), 32'hB);
        wait_pending(1, 40, k);
        wr(ra(1, STATUS_OFF), 32'd1);
        wait_pending(1, 20, k);
        check("reload_period_p3", 32'(k + 1), 32'd5);
        wr(ra(1, PRESET_OFF), 32'd6);
        wr(ra(1, STATUS_OFF), 32'd1);
        wait_pending(1, 20, k);
        check("reload_period_before_reload", 32'(k + 2), 32'd5);
        wr(ra(1, STATUS_OFF), 32'd1);
        wait_pending(1, 20, k);
        check("reload_period_p6", 32'(k + 1), 32'd8);
        wr(ra(1, CTRL_OFF), 32'd0);
        wr(ra(1, STATUS_OFF), 32'd1);

        // Free-run on ch2 never interrupts.
        wr(ra(2, PRESET_OFF), 32'd2);
        wr(ra(2, CTRL_OFF), 32'hD);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            rd(ra(2, COUNT_OFF)); #1;
            if (irq) seen = 1;
        end
        check("freerun_irq", 32'(seen), 32'd0);
        wr(ra(2, CTRL_OFF), 32'd0);

        // Masked one-shot, then unmask and re-mask.
        wr(ra(0, PRESET_OFF), 32'd2);
        wr(ra(0, CTRL_OFF), 32'h1);
        idle(8);
        rd(ra(0, STATUS_OFF)); #1;
        check("masked_pending", bus.rdata, 32'd1);
        check("masked_irq", 32'(irq), 32'd0);
        wr(ra(0, CTRL_OFF), 32'h8); #1;
        check("unmask_irq", 32'(irq), 32'd1);
        wr(ra(0, CTRL_OFF), 32'h0); #1;
        check("remask_irq", 32'(irq), 32'd0);
        rd(ra(0, STATUS_OFF)); #1;
        check("remask_pending", bus.rdata, 32'd1);
        wr(ra(0, STATUS_OFF), 32'd1);

        // W1C on the expiry edge: the set wins.
        wr(ra(0, CTRL_OFF), 32'h9);
        idle(4);
        wr(ra(0, STATUS_OFF), 32'd1); #1;
        check("w1c_vs_set", 32'(irq_vec[0]), 32'd1);
        wr(ra(0, STATUS_OFF), 32'd1); #1;
        check("w1c_clear", 32'(irq), 32'd0);

        // CTRL write on the expiry edge of an auto-reload channel.
        wr(ra(1, PRESET_OFF), 32'd4);
        wr(ra(1, CTRL_OFF), 32'hB);
        idle(6);
        wr(ra(1, CTRL_OFF), 32'h8); #1;
        check("ctrl_vs_fire_pend", 32'(irq_vec[1]), 32'd1);
        rd(ra(1, CTRL_OFF)); #1;
        check("ctrl_vs_fire_ctrl", bus.rdata, 32'h8);
        idle(3);
        wr(ra(1, STATUS_OFF), 32'd1);

        // EN cleared mid-count freezes COUNT; re-enable restarts from PRESET.
        wr(ra(2, PRESET_OFF), 32'd10);
        wr(ra(2, CTRL_OFF), 32'h1);
        idle(4);
        wr(ra(2, CTRL_OFF), 32'h0);
        idle(3);
        rd(ra(2, COUNT_OFF)); #1;
        check("freeze_count_a", bus.rdata, 32'd7);
        idle(2);
        rd(ra(2, COUNT_OFF)); #1;
        check("freeze_count_b", bus.rdata, 32'd7);
        wr(ra(2, CTRL_OFF), 32'h1);
        idle(1);
        rd(ra(2, COUNT_OFF)); #1;
        check("restart_count", bus.rdata, 32'd10);
        wr(ra(2, CTRL_OFF), 32'h0);

        // Decode: truncation, byte-lane aliasing, out-of-range accesses.
        wr(ra(1, PRESET_OFF), 32'h0001_2345);
        rd(ra(1, PRESET_OFF)); #1;
        check("preset_trunc", bus.rdata, 32'h2345);
        wr(ra(1, PRESET_OFF) + 32'd2, 32'd7);
        rd(ra(1, PRESET_OFF) + 32'd1); #1;
        check("byte_lane_alias", bus.rdata, 32'd7);
        wr(BASE + 32'h30, 32'hFFFF_FFFF);
        rd(BASE + 32'h30); #1;
        check("oob_read_hi", bus.rdata, 32'd0);
        wr(BASE - 32'd4, 32'hFFFF_FFFF);
        rd(BASE - 32'd4); #1;
        check("oob_read_lo", bus.rdata, 32'd0);

        // Simultaneous expiry of ch0 and ch2.
        wr(ra(0, PRESET_OFF), 32'd4);
        wr(ra(2, PRESET_OFF), 32'd3);
        wr(ra(0, CTRL_OFF), 32'h9);
        wr(ra(2, CTRL_OFF), 32'h9);
        k = -1;
        for (int i = 0; i < 30; i++) begin
            rd(ra(0, STATUS_OFF)); #1;
            if (irq_vec != '0) begin k = i; break; end
        end
        check("simul_vec", 32'(irq_vec), 32'b101);
        wr(ra(0, STATUS_OFF), 32'd1);
        wr(ra(2, STATUS_OFF), 32'd1);

        // Reset mid-count with a write on the reset edge.
        wr(ra(0, PRESET_OFF), 32'd9);  wr(ra(0, CTRL_OFF), 32'hB);
        wr(ra(1, PRESET_OFF), 32'd5);  wr(ra(1, CTRL_OFF), 32'h9);
        wr(ra(2, PRESET_OFF), 32'd2);  wr(ra(2, CTRL_OFF), 32'hD);
        idle(12);
        cycle(1'b1, 1'b1, ra(0, CTRL_OFF), 32'hF);
        for (int c = 0; c < NCH; c++)
            for (int o = 0; o < 4; o++) begin
                rd(ra(c, 4'(o * 4))); #1;
                check($sformatf("reset_sweep_ch%0d_off%0d", c, o * 4), bus.rdata, 32'd0);
            end
        check("reset_sweep_irq", 32'(irq), 32'd0);
        check("reset_sweep_vec", 32'(irq_vec), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            int unsigned r;
            int unsigned ch;
            int unsigned w;
            logic [31:0] a;
            logic [31:0] d;
            r  = $urandom_range(0, 99);
            ch = $urandom_range(0, 3);
            w  = $urandom_range(0, 3);
            a  = BASE + 32'(16 * ch + 4 * w) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) a = $urandom;
            if ($urandom_range(0, 499) == 0) begin
                cycle(1'b1, 1'b1, a, $urandom);
            end else if (r < 30) begin
                if (w == 1) d = 32'($urandom_range(0, 8)) | ($urandom_range(0, 1) != 0 ? ($urandom & 32'hFFFF_0000) : 32'd0);
                else        d = $urandom;
                wr(a, d);
            end else begin
                rd(a);
            end
        end

        idle(2);
        #3;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
